// File: rtl/key_event_det_pkg.sv
// Shared types and default timing for the push-button event detector.
package key_event_det_pkg;

  // Per-channel controller states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_PRESSED  = 3'd2,
    ST_LONG     = 3'd3,
    ST_RELEASE  = 3'd4
  } key_state_e;

  // Board defaults at 50 MHz: 4 ms debounce, 1 s long press, no auto-repeat.
  localparam int unsigned DEF_CNT_W        = 32;
  localparam int unsigned DEF_DEBOUNCE_CYC = 200_000;
  localparam int unsigned DEF_LONG_CYC     = 50_000_000;
  localparam int unsigned DEF_REPEAT_CYC   = 0;

endpackage

// File: rtl/key_event_det_ch.sv
// One key channel: 2-flop synchronizer, press debounce, release filter,
// hold/repeat counters and registered level/event outputs.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | key inactive, level 0, waiting for first active sample
// DEBOUNCE   | counting consecutive active samples towards acceptance
// PRESSED    | press accepted, level 1; release here yields key_short
// LONG       | key_long fired; repeat timer runs while still held
// RELEASE    | level still 1; counting consecutive inactive samples
//
// hold_q counts consecutive active samples before the current one while the
// key is down, and is reused for consecutive inactive samples in RELEASE.
module key_event_det_ch
  import key_event_det_pkg::*;
#(
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned LONG_CYC     = DEF_LONG_CYC,
  parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_level,
  output logic key_short,
  output logic key_long,
  output logic key_repeat
);

  localparam logic [CNT_W-1:0] DEB_C    = CNT_W'(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] LONG_C   = CNT_W'(LONG_CYC);
  // Repeat timer is a down-counter reloaded with REPEAT_CYC-1 so that
  // consecutive pulses are exactly REPEAT_CYC cycles apart.
  localparam logic [CNT_W-1:0] RPT_LOAD = (REPEAT_CYC == 0) ? '0 : CNT_W'(REPEAT_CYC - 1);

  logic [1:0]       sync_q;
  logic             act;
  key_state_e       state_q, state_nxt;
  logic [CNT_W-1:0] hold_q, hold_nxt, hold_inc;
  logic [CNT_W-1:0] rpt_q, rpt_nxt;
  logic             level_nxt, short_nxt, long_nxt, rep_nxt;

  // Bring the raw pin into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], key_in};
  end

  assign act      = ACTIVE_LOW ? ~sync_q[1] : sync_q[1];
  assign hold_inc = (&hold_q) ? hold_q : hold_q + CNT_W'(1);

  // Next-state, counter and event decode.
  always_comb begin
    state_nxt = state_q;
    hold_nxt  = hold_q;
    rpt_nxt   = rpt_q;
    level_nxt = key_level;
    short_nxt = 1'b0;
    long_nxt  = 1'b0;
    rep_nxt   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (act) begin
          state_nxt = ST_DEBOUNCE;
          hold_nxt  = CNT_W'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (!act) begin
          state_nxt = ST_IDLE;
          hold_nxt  = '0;
        end else begin
          hold_nxt = hold_inc;
          if (hold_q == DEB_C) begin
            state_nxt = ST_PRESSED;
            level_nxt = 1'b1;
          end
        end
      end
      ST_PRESSED: begin
        if (!act) begin
          state_nxt = ST_RELEASE;
          short_nxt = 1'b1;
          hold_nxt  = CNT_W'(1);
        end else begin
          hold_nxt = hold_inc;
          if (hold_q == LONG_C) begin
            state_nxt = ST_LONG;
            long_nxt  = 1'b1;
            rpt_nxt   = RPT_LOAD;
          end
        end
      end
      ST_LONG: begin
        if (!act) begin
          state_nxt = ST_RELEASE;
          hold_nxt  = CNT_W'(1);
        end else begin
          hold_nxt = hold_inc;
          if (REPEAT_CYC != 0) begin
            if (rpt_q == '0) begin
              rep_nxt = 1'b1;
              rpt_nxt = RPT_LOAD;
            end else begin
              rpt_nxt = rpt_q - CNT_W'(1);
            end
          end
        end
      end
      ST_RELEASE: begin
        if (act) begin
          hold_nxt = '0;
        end else if (hold_q == DEB_C) begin
          state_nxt = ST_IDLE;
          level_nxt = 1'b0;
          hold_nxt  = '0;
        end else begin
          hold_nxt = hold_inc;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        hold_nxt  = '0;
        level_nxt = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      rpt_q      <= '0;
      key_level  <= 1'b0;
      key_short  <= 1'b0;
      key_long   <= 1'b0;
      key_repeat <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      hold_q     <= hold_nxt;
      rpt_q      <= rpt_nxt;
      key_level  <= level_nxt;
      key_short  <= short_nxt;
      key_long   <= long_nxt;
      key_repeat <= rep_nxt;
    end
  end

endmodule

// File: rtl/key_event_det.sv
// N-channel push-button event detector: one independent channel per key,
// plus elaboration-time sanity checks on the timing parameters.
module key_event_det
  import key_event_det_pkg::*;
#(
  parameter int unsigned N_KEYS       = 1,
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned LONG_CYC     = DEF_LONG_CYC,
  parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_short,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat
);

  // Reject timing combinations the channel counters cannot represent.
  if (DEBOUNCE_CYC == 0) begin : g_bad_debounce
    $error("key_event_det: DEBOUNCE_CYC must be at least 1");
  end
  if (LONG_CYC <= DEBOUNCE_CYC) begin : g_bad_long
    $error("key_event_det: LONG_CYC must exceed DEBOUNCE_CYC");
  end
  if ((LONG_CYC >> CNT_W) != 0) begin : g_bad_width
    $error("key_event_det: LONG_CYC does not fit in CNT_W bits");
  end
  if ((REPEAT_CYC >> CNT_W) != 0) begin : g_bad_repeat
    $error("key_event_det: REPEAT_CYC does not fit in CNT_W bits");
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_event_det_ch #(
      .CNT_W        (CNT_W),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .REPEAT_CYC   (REPEAT_CYC),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_in     (key_in[i]),
      .key_level  (key_level[i]),
      .key_short  (key_short[i]),
      .key_long   (key_long[i]),
      .key_repeat (key_repeat[i])
    );
  end

endmodule
